coin_vend_frontend: RTL and testbench

//  Payment/request front end that drives the wash control unit's coin_in and double_wash inputs.
//  - Synchronises and qualifies the raw coin sensor, then accumulates credit.
//  - Holds a wash request (coin_in level) until the control unit acknowledges that a cycle started.
//  - Issues no new request until the control unit reports wash_done.

---
 rtl/coin_vend_frontend_pkg.sv | 12 +
 rtl/coin_vend_frontend_qualifier.sv | 95 +++++++++
 rtl/coin_vend_frontend.sv | 147 ++++++++++++++
 tb/tb_coin_vend_frontend.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_vend_frontend_pkg.sv
// Shared types for the wash front end: coin/vend FSM states and qualifier events.
package coin_vend_frontend_pkg;

    typedef enum logic [1:0] {C_LOW, C_HIGH, C_JAM} coin_state_t;
    typedef enum logic [1:0] {IDLE, REQ, RUN, DRAIN} vend_state_t;
    typedef enum logic [1:0] {EV_NONE, EV_OK, EV_REJECT} coin_evt_t;

    function automatic int unsigned wash_cost(input logic dbl, input int unsigned price);
        return dbl ? 2 * price : price;
    endfunction

endpackage

// File: rtl/coin_vend_frontend_qualifier.sv
// Sync + debounce of one raw input, optionally followed by a coin pulse width check.
// With WIDTH_CHECK=0 every debounced rise is reported as EV_OK.
module coin_pulse_qualifier
    import coin_vend_frontend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned MIN_PULSE    = 8,
    parameter int unsigned MAX_PULSE    = 1024,
    parameter bit          WIDTH_CHECK  = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      raw,
    output coin_evt_t evt
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned WW  = $clog2(MAX_PULSE + 2);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [WW-1:0]  W_MIN   = WW'(MIN_PULSE);
    localparam logic [WW-1:0]  W_MAX   = WW'(MAX_PULSE);

    logic           sync_1;
    logic           sync_2;
    logic           level;
    logic [DBW-1:0] db_cnt;
    logic [WW-1:0]  width;
    coin_state_t    state;
    logic           take;
    logic           rise;
    logic           fall;

    assign take = (sync_2 != level) && (db_cnt == DB_LAST);
    assign rise = take && sync_2;
    assign fall = take && !sync_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                db_cnt <= '0;
            end else if (take) begin
                level  <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Edges are acted on in the cycle the debounced level changes; width counts debounced high cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= C_LOW;
            width <= '0;
            evt   <= EV_NONE;
        end else begin
            evt <= EV_NONE;
            if (!WIDTH_CHECK) begin
                if (rise) evt <= EV_OK;
            end else begin
                case (state)
                    C_LOW: begin
                        if (rise) begin
                            state <= C_HIGH;
                            width <= WW'(1);
                        end
                    end
                    C_HIGH: begin
                        if (fall) begin
                            evt   <= (width >= W_MIN) ? EV_OK : EV_REJECT;
                            state <= C_LOW;
                        end else if (width == W_MAX) begin
                            evt   <= EV_REJECT;
                            state <= C_JAM;
                        end else begin
                            width <= width + 1'b1;
                        end
                    end
                    C_JAM: begin
                        if (fall) state <= C_LOW;
                    end
                    default: state <= C_LOW;
                endcase
            end
        end
    end

endmodule

// File: rtl/coin_vend_frontend.sv
// Payment front end: credit counter, double-wash latch and the vend request FSM
// driving the wash control unit's coin_in / double_wash inputs.
module coin_vend_frontend
    import coin_vend_frontend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned MIN_PULSE    = 8,
    parameter int unsigned MAX_PULSE    = 1024,
    parameter int unsigned PRICE        = 2,
    parameter int unsigned CREDIT_W     = 4,
    parameter int unsigned REQ_TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_sense,
    input  logic                double_btn,
    input  logic                wash_ack,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                req_timeout
);

    localparam int unsigned RTW = $clog2(REQ_TIMEOUT + 1);
    localparam int unsigned DRW = $clog2(2 * DEBOUNCE_CYC + 1);
    localparam logic [RTW-1:0]      REQ_LAST   = RTW'(REQ_TIMEOUT - 1);
    localparam logic [DRW-1:0]      DRAIN_LAST = DRW'(2 * DEBOUNCE_CYC - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_SAT = '1;

    coin_evt_t         coin_evt;
    coin_evt_t         btn_evt;
    vend_state_t       state;
    logic              dbl_latch;
    logic [RTW-1:0]    req_cnt;
    logic [DRW-1:0]    drain_cnt;
    logic [CREDIT_W:0] cost;
    logic [CREDIT_W:0] credit_next;
    logic              deduct;
    logic              lost_inc;
    logic              can_vend;
    logic              coin_ok;
    logic              coin_bad;
    logic              btn_rise;

    coin_pulse_qualifier #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .MIN_PULSE    (MIN_PULSE),
        .MAX_PULSE    (MAX_PULSE),
        .WIDTH_CHECK  (1'b1)
    ) u_coin_q (
        .clk (clk),
        .rst (rst),
        .raw (coin_sense),
        .evt (coin_evt)
    );

    coin_pulse_qualifier #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .MIN_PULSE    (MIN_PULSE),
        .MAX_PULSE    (MAX_PULSE),
        .WIDTH_CHECK  (1'b0)
    ) u_btn_q (
        .clk (clk),
        .rst (rst),
        .raw (double_btn),
        .evt (btn_evt)
    );

    assign coin_ok  = (coin_evt == EV_OK);
    assign coin_bad = (coin_evt == EV_REJECT);
    assign btn_rise = (btn_evt == EV_OK);

    // cost <= credit holds throughout REQ (latch frozen, credit only grows), so no underflow.
    always_comb begin
        cost        = (CREDIT_W + 1)'(wash_cost(dbl_latch, PRICE));
        deduct      = (state == REQ) && wash_ack;
        credit_next = {1'b0, credit} + {{CREDIT_W{1'b0}}, coin_ok};
        if (deduct) credit_next = credit_next - cost;
        lost_inc    = credit_next > {1'b0, CREDIT_SAT};
        can_vend    = {1'b0, credit} >= cost;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_bad || lost_inc;
            credit      <= lost_inc ? CREDIT_SAT : credit_next[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dbl_latch   <= 1'b0;
            req_cnt     <= '0;
            drain_cnt   <= '0;
            coin_in     <= 1'b0;
            double_wash <= 1'b0;
            req_timeout <= 1'b0;
        end else begin
            req_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_vend) begin
                        state       <= REQ;
                        coin_in     <= 1'b1;
                        double_wash <= dbl_latch;
                        req_cnt     <= '0;
                    end else if (btn_rise) begin
                        dbl_latch <= !dbl_latch;
                    end
                end
                REQ: begin
                    if (deduct) begin
                        coin_in <= 1'b0;
                        state   <= RUN;
                    end else if (req_cnt == REQ_LAST) begin
                        coin_in     <= 1'b0;
                        double_wash <= 1'b0;
                        req_timeout <= 1'b1;
                        drain_cnt   <= '0;
                        state       <= DRAIN;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (wash_done) begin
                        double_wash <= 1'b0;
                        dbl_latch   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= IDLE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_vend_frontend.sv
// Self-checking bench for coin_vend_frontend against a transaction-level credit/request model.
module tb_coin_vend_frontend;

    // Short debounce so a sub-MIN_PULSE coin can pass the debouncer and be seen as a bad width.
    localparam int unsigned DB     = 4;
    localparam int unsigned MINP   = 8;
    localparam int unsigned MAXP   = 1024;
    localparam int unsigned PRICE  = 2;
    localparam int unsigned CW     = 4;
    localparam int unsigned TMO    = 4096;
    localparam int unsigned CMAX   = (1 << CW) - 1;
    localparam int unsigned LAT    = DB + 3;   // raw edge to credit/coin_reject update
    localparam int unsigned SETTLE = LAT + 6;

    typedef enum {M_IDLE, M_REQ, M_RUN} mphase_t;

    logic clk = 1'b0;
    logic rst, coin_sense, double_btn, wash_ack, wash_done;
    logic coin_in, double_wash, coin_reject, req_timeout;
    logic [CW-1:0] credit;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned rej_seen = 0;
    int unsigned tmo_seen = 0;

    int unsigned m_credit = 0;
    int unsigned m_rej = 0;
    bit          m_latch = 1'b0;
    mphase_t     m_phase = M_IDLE;

    coin_vend_frontend #(
        .DEBOUNCE_CYC (DB),
        .MIN_PULSE    (MINP),
        .MAX_PULSE    (MAXP),
        .PRICE        (PRICE),
        .CREDIT_W     (CW),
        .REQ_TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_sense  (coin_sense),
        .double_btn  (double_btn),
        .wash_ack    (wash_ack),
        .wash_done   (wash_done),
        .coin_in     (coin_in),
        .double_wash (double_wash),
        .credit      (credit),
        .coin_reject (coin_reject),
        .req_timeout (req_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (coin_reject === 1'b1) rej_seen++;
        if (req_timeout === 1'b1) tmo_seen++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int unsigned m_cost();
        return m_latch ? 2 * PRICE : PRICE;
    endfunction

    task automatic m_eval();
        if (m_phase == M_IDLE && m_credit >= m_cost()) m_phase = M_REQ;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".credit"}, credit, m_credit);
        check_eq({tag, ".rejects"}, rej_seen, m_rej);
        check_eq({tag, ".coin_in"}, coin_in, m_phase == M_REQ);
        check_eq({tag, ".double_wash"}, double_wash, (m_phase != M_IDLE) && m_latch);
    endtask

    task automatic insert_coin(input int unsigned w);
        coin_sense = 1'b1;
        tick(w);
        coin_sense = 1'b0;
        tick(SETTLE);
        if (w >= DB) begin
            if (w < MINP || w > MAXP) m_rej++;
            else if (m_credit == CMAX) m_rej++;
            else m_credit++;
        end
        m_eval();
        check_outputs("coin");
    endtask

    task automatic press_btn();
        double_btn = 1'b1;
        tick(DB + 4);
        double_btn = 1'b0;
        tick(SETTLE);
        if (m_phase == M_IDLE) begin
            m_latch = !m_latch;
            m_eval();
        end
        check_outputs("btn");
    endtask

    task automatic do_ack();
        wash_ack = 1'b1;
        tick(1);
        m_credit -= m_cost();
        m_phase = M_RUN;
        check_outputs("ack");
    endtask

    task automatic finish_run(input int unsigned hold);
        tick(hold);
        wash_ack = 1'b0;
        tick(1);
        check_outputs("run");
        wash_done = 1'b1;
        tick(1);
        wash_done = 1'b0;
        m_phase = M_IDLE;
        m_latch = 1'b0;
        check_eq("done.coin_in", coin_in, 0);
        check_eq("done.double_wash", double_wash, 0);
        tick(1);
        m_eval();
        check_outputs("idle");
    endtask

    task automatic reset_mid_op(input string tag);
        rst = 1'b1;
        #2;
        check_eq({tag, ".coin_in"}, coin_in, 0);
        check_eq({tag, ".double_wash"}, double_wash, 0);
        check_eq({tag, ".credit"}, credit, 0);
        check_eq({tag, ".coin_reject"}, coin_reject, 0);
        check_eq({tag, ".req_timeout"}, req_timeout, 0);
        tick(2);
        rst = 1'b0;
        wash_ack = 1'b0;
        tick(2);
        m_credit = 0;
        m_latch = 1'b0;
        m_phase = M_IDLE;
        check_outputs({tag, ".after"});
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1;
        coin_sense = 1'b0;
        double_btn = 1'b0;
        wash_ack = 1'b0;
        wash_done = 1'b0;
        tick(3);
        check_eq("reset.coin_in", coin_in, 0);
        check_eq("reset.double_wash", double_wash, 0);
        check_eq("reset.credit", credit, 0);
        check_eq("reset.coin_reject", coin_reject, 0);
        check_eq("reset.req_timeout", req_timeout, 0);
        rst = 1'b0;
        tick(2);

        // Two coins make a single-wash request; ack 300 cycles later deducts the price.
        insert_coin(50);
        insert_coin(50);
        tick(300);
        check_outputs("t1.wait");
        do_ack();
        finish_run(3);

        // Bad widths: too short, filtered by debounce, jammed, and just below minimum.
        insert_coin(5);
        insert_coin(2);
        coin_sense = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (coin_reject !== 1'b1 && n < MAXP + 200);
        check_eq("jam.reject_cycle", n, LAT + MAXP);
        tick(2000 - n);
        coin_sense = 1'b0;
        tick(SETTLE);
        m_rej++;
        check_outputs("jam");
        insert_coin(7);

        // Double wash: three coins are not enough, the fourth requests with double_wash.
        press_btn();
        insert_coin(30);
        insert_coin(30);
        insert_coin(30);
        insert_coin(30);
        wash_done = 1'b1;
        tick(1);
        wash_done = 1'b0;
        tick(1);
        check_outputs("done_in_req");
        do_ack();
        finish_run(4);

        // Fill to saturation while the request is pending, then land a coin on the ack cycle.
        insert_coin(MINP);
        insert_coin(MAXP);
        while (m_credit < CMAX) insert_coin(20);
        insert_coin(20);
        coin_sense = 1'b1;
        tick(20);
        coin_sense = 1'b0;
        tick(LAT - 1);
        wash_ack = 1'b1;
        tick(1);
        m_credit = m_credit + 1 - m_cost();
        if (m_credit > CMAX) begin
            m_credit = CMAX;
            m_rej++;
        end
        m_phase = M_RUN;
        check_outputs("collide");
        tick(SETTLE);
        check_outputs("collide.settle");
        finish_run(0);
        do_ack();
        reset_mid_op("rst_a");

        // No ack: request times out, credit is kept, request returns after the drain window.
        insert_coin(20);
        insert_coin(20);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (coin_in !== 1'b0 && n < TMO + 100);
        check_eq("tmo.latency", n, TMO - (SETTLE - LAT - 1));
        check_eq("tmo.pulse", req_timeout, 1);
        check_eq("tmo.credit", credit, m_credit);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (coin_in !== 1'b1 && n < 100);
        check_eq("tmo.retry", n, 2 * DB + 1);
        check_eq("tmo.count", tmo_seen, 1);
        check_outputs("tmo.after");

        // Reset while running with credit 3.
        do_ack();
        insert_coin(15);
        insert_coin(15);
        insert_coin(15);
        reset_mid_op("rst_run");

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (m_phase == M_REQ && r < 4) begin
                do_ack();
                finish_run($urandom_range(0, 5));
            end else if (m_phase == M_IDLE && r < 2) begin
                press_btn();
            end else if (r == 9) begin
                insert_coin($urandom_range(5, MINP - 1));
            end else begin
                insert_coin($urandom_range(MINP, 40));
            end
        end
        check_eq("final.timeouts", tmo_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
